dcr_rf_wb_arbiter: RTL
======================

# dcr_rf_wb_arbiter

Shares the single register-file write port between two writeback sources: requester 0 is the ALU pipe and requester 1 is the load unit. Arbitration is round-robin, and the winning write is registered onto the register-file write port. A per-register pending-write scoreboard is kept alongside. Issue logic reserves a destination register, and the block clears that reservation when the matching write retires. The block sits between the execute/memory writeback stage and the 32x32 register file.

## Interface
- `DATA_W`, 32, register data width
- `ADDR_W`, 5, register address width; register count is 2**ADDR_W

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; one clock, synchronous and active-high
- `req_valid`  in  2  per-requester write valid
- `req_addr`  in  2 x ADDR_W  per-requester destination register
- `req_data`  in  2 x DATA_W  per-requester write data
- `req_ready`  out  2  per-requester grant; transfer occurs when valid & ready
- `rf_wren`  out  1  register-file write enable
- `rf_wraddr`  out  ADDR_W  register-file write address
- `rf_wrdata`  out  DATA_W  register-file write data
- `rsv_en`  in  1  reserve pending write
- `rsv_addr`  in  ADDR_W  register to reserve
- `busy`  out  2**ADDR_W  pending-write flag per register; bit 0 always 0

## Operation
Arbitration:
- `req_ready` is combinational from `req_valid` and the priority pointer `prio`.
- At most one bit of `req_ready` is high per cycle.
- `req_ready[i]` is never high without `req_valid[i]`.
- If only one requester is valid, it is granted.
- If both are valid, `prio` selects the winner. After each grant taken in a contended cycle, `prio` flips to the loser.
- `prio` is unchanged on uncontended cycles and idle cycles.

Requester rules:
- `req_addr`/`req_data` are held stable while `req_valid` is high and `req_ready` is low.
- `req_valid` is not dropped before the transfer.

Output register:
- On a transfer, the next cycle shows `rf_wren`=1 with the accepted `rf_wraddr` and `rf_wrdata`.
- With no transfer, `rf_wren`=0. `rf_wraddr`/`rf_wrdata` hold their last values.

Writes to register 0:
- Accepted (ready asserts normally).
- `rf_wren` stays 0 the next cycle.
- The scoreboard is not touched.

Scoreboard:
- `busy[a]` sets at the edge where `rsv_en` is high with `rsv_addr`=a, a≠0.
- `busy[a]` clears at the edge ending the cycle where `rf_wren` is high with `rf_wraddr`=a. This is the same edge at which the register file captures the data.
- Reserve and clear of the same register at the same edge: reserve wins, and `busy` stays 1.
- `rsv_addr`=0 is ignored.
- A clear of a non-busy register is a no-op.

The scoreboard does not count reservations. A second reserve of an already-busy register leaves a single pending bit. Issue logic must not issue a second writer to a busy register.

## Timing
Reset, effective at the first rising edge with `rst`=1:
- `rf_wren`=0, `rf_wraddr`=0, `rf_wrdata`=0
- `busy`=all zeros
- `prio`=0, so requester 0 wins the first contention

While `rst` is high:
- `req_ready`=0
- No transfer is accepted.
- No reservation is recorded.

Latency:
- Request accepted in cycle N → `rf_wren` high in cycle N+1.
- Register file updated at the end of N+1.
- `busy` bit low from cycle N+2.

Throughput is one write per cycle in aggregate. Under continuous contention, each requester gets every other cycle, and worst-case wait is 1 cycle.

If reset is asserted mid-operation, an in-flight output write (the transfer in the cycle before reset) is dropped. `rf_wren` is 0 in the cycle after the reset edge.

## Structure
Package `dcr_pkg` holds:
- `DCR_DATA_W`=32
- `DCR_ADDR_W`=5
- `DCR_NUM_WB`=2
- `typedef struct packed { logic [DCR_ADDR_W-1:0] addr; logic [DCR_DATA_W-1:0] data; } dcr_wb_t`

Sub-module `dcr_rr_arb2`:
- 2-way round-robin arbiter: valid in, one-hot grant out, internal `prio` flop.
- Reused later for other shared ports.

The scoreboard stays inline as a `2**ADDR_W` flop vector with set/clear logic.

## Test plan
- Reset, then `req_valid`=2'b01, addr 5, data 0xDEADBEEF → `req_ready`=2'b01 same cycle. Next cycle `rf_wren`=1, `rf_wraddr`=5, `rf_wrdata`=0xDEADBEEF. Following cycle `rf_wren`=0.
- Both requesters valid for 4 cycles (addr 1/data 0x11 and addr 2/data 0x22) → grants in order 0,1,0,1. `rf_wraddr` sequence 1,2,1,2, each one cycle after its grant.
- `rsv_en` with addr 7 → `busy[7]`=1 next cycle. Requester 1 then writes reg 7 → `busy[7]`=0 two cycles after acceptance. Other bits are unaffected throughout.
- Reserve reg 3 at the same edge as a retiring write to reg 3 → `busy[3]`=1 afterwards. Separately, `rsv_addr`=0 → `busy[0]`=0.
- Write to reg 0 with data 0xFFFFFFFF → `req_ready` asserted, next cycle `rf_wren`=0.
- Reset mid-stream with one write accepted the cycle before the reset edge → `rf_wren`=0, `busy`=0, `req_ready`=0 while `rst` is high. After release, requester 0 wins the first contention.

Source files
------------

// File: rtl/dcr_pkg.sv
// Shared widths and writeback request type for the register-file writeback path.
package dcr_pkg;

    localparam int DCR_DATA_W = 32;
    localparam int DCR_ADDR_W = 5;
    localparam int DCR_NUM_WB = 2;

    typedef struct packed {
        logic [DCR_ADDR_W-1:0] addr;
        logic [DCR_DATA_W-1:0] data;
    } dcr_wb_t;

endpackage

// File: rtl/dcr_rr_arb2.sv
// Two-way round-robin arbiter with a one-hot grant that follows valid in the same cycle.
module dcr_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    // prio names the requester that wins the next contended cycle
    logic prio;

    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            unique case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = prio ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // A contended grant always goes to prio, so the loser is simply ~prio
    always_ff @(posedge clk) begin
        if (rst)
            prio <= 1'b0;
        else if (&valid)
            prio <= ~prio;
    end

endmodule

// File: rtl/dcr_rf_wb_arbiter.sv
// Arbitrates ALU and load-unit writebacks onto the register-file write port and
// tracks per-register pending writes reserved at issue.
module dcr_rf_wb_arbiter
    import dcr_pkg::*;
#(
    parameter int DATA_W = DCR_DATA_W,
    parameter int ADDR_W = DCR_ADDR_W
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [DCR_NUM_WB-1:0]                  req_valid,
    input  logic [DCR_NUM_WB-1:0][ADDR_W-1:0]      req_addr,
    input  logic [DCR_NUM_WB-1:0][DATA_W-1:0]      req_data,
    output logic [DCR_NUM_WB-1:0]                  req_ready,
    output logic                                   rf_wren,
    output logic [ADDR_W-1:0]                      rf_wraddr,
    output logic [DATA_W-1:0]                      rf_wrdata,
    input  logic                                   rsv_en,
    input  logic [ADDR_W-1:0]                      rsv_addr,
    output logic [(2**ADDR_W)-1:0]                 busy
);

    localparam int NREG = 2**ADDR_W;

    logic              xfer;
    logic              sel;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_nxt;

    dcr_rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid (req_valid),
        .grant (req_ready)
    );

    assign xfer     = |req_ready;
    assign sel      = req_ready[1];
    assign win_addr = req_addr[sel];
    assign win_data = req_data[sel];

    // Writes to r0 are consumed but never reach the register file
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wren   <= 1'b0;
            rf_wraddr <= '0;
            rf_wrdata <= '0;
        end else begin
            rf_wren <= xfer && (win_addr != '0);
            if (xfer) begin
                rf_wraddr <= win_addr;
                rf_wrdata <= win_data;
            end
        end
    end

    // Set is applied after clear so a same-edge reserve keeps the bit high
    always_comb begin
        busy_nxt = busy_q;
        if (rf_wren)
            busy_nxt[rf_wraddr] = 1'b0;
        if (rsv_en)
            busy_nxt[rsv_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy_q <= '0;
        else
            busy_q <= busy_nxt;
    end

    assign busy = busy_q;

endmodule
